// File: rtl/vga_bus_reorder_pkg.sv
// Shared constants for the VGA bus reorder stage: permutation mode codes and mode width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vga_bus_reorder_pkg;

    // Width of the per-transfer permutation mode field
    localparam int MODE_W = 2;

    // Permutation mode codes, sampled with each accepted word
    localparam logic [MODE_W-1:0] MODE_PASS     = 2'b00;
    localparam logic [MODE_W-1:0] MODE_REV      = 2'b01;
    localparam logic [MODE_W-1:0] MODE_LANE_REV = 2'b10;
    localparam logic [MODE_W-1:0] MODE_LANE_SWP = 2'b11;

endpackage

// File: rtl/vga_bus_reorder_skid_buffer.sv
// Generic 2-register valid/ready stage: an output register plus one skid register.
// Latency: a word accepted at edge N is presented on out_data after edge N.
// Backpressure: in_ready drops only once the skid register is occupied; the skid drains first, keeping order.
//
// Ports:
//   clk20ns, rst_n                : clock, synchronous active-low reset
//   in_valid/in_ready/in_data     : upstream handshake, DW-bit payload
//   out_valid/out_ready/out_data  : downstream handshake, DW-bit payload
module vga_skid_buffer #(
    parameter int DW = 11
) (
    input  logic          clk20ns,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          skid_valid;
    logic [DW-1:0] skid_data;
    logic          accept;
    logic          out_load;

    // in_ready depends only on a register and the reset gate, never on out_ready
    assign in_ready = ~skid_valid & rst_n;
    assign accept   = in_valid & in_ready;
    // Output register may take a new word when it is empty or being consumed this edge
    assign out_load = ~out_valid | out_ready;

    always_ff @(posedge clk20ns) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            if (out_load) begin
                if (skid_valid) begin
                    // Older skid word goes first; in_ready was low so nothing new arrives now
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= accept;
                    if (accept) begin
                        out_data <= in_data;
                    end
                end
            end else if (accept) begin
                // Output stalled: park the incoming word
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/vga_bus_reorder.sv
// Registered bit-order permutation stage for the VGA video data bus (PASS/REV/LANE_REV/LANE_SWP).
// Latency: 1 cycle; a word accepted at edge N is on out_data after edge N.
// Backpressure: 2-entry skid buffer; in_ready falls only when the skid holds a word, order preserved.
//
// Optional feature macro: VGA_REORDER_PARITY_EN adds out_parity (XOR of the permuted word).
// Ports:
//   clk20ns, rst_n                : clock, synchronous active-low reset
//   in_valid/in_ready/in_data     : input word handshake, WIDTH bits
//   in_mode                       : permutation mode, sampled with in_data
//   out_valid/out_ready/out_data  : permuted word handshake, WIDTH bits
//   out_parity                    : parity of out_data (only with VGA_REORDER_PARITY_EN)
module vga_bus_reorder
    import vga_bus_reorder_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int LANES = 1
) (
    input  logic              clk20ns,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
`ifdef VGA_REORDER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int LANE_W = WIDTH / LANES;

`ifdef VGA_REORDER_PARITY_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    logic [WIDTH-1:0] perm_rev;
    logic [WIDTH-1:0] perm_lrev;
    logic [WIDTH-1:0] perm_lswp;
    logic [WIDTH-1:0] perm_data;
    logic [DW-1:0]    skid_in;
    logic [DW-1:0]    skid_out;

    // Fixed wiring for each mode; bit n sits at lane L, position K within the lane
    for (genvar n = 0; n < WIDTH; n++) begin : g_bit
        localparam int L = n / LANE_W;
        localparam int K = n % LANE_W;
        assign perm_rev[n]  = in_data[WIDTH-1-n];
        assign perm_lrev[n] = in_data[L*LANE_W + LANE_W-1-K];
        assign perm_lswp[n] = in_data[(LANES-1-L)*LANE_W + K];
    end

    always_comb begin
        perm_data = in_data;
        case (in_mode)
            MODE_PASS:     perm_data = in_data;
            MODE_REV:      perm_data = perm_rev;
            MODE_LANE_REV: perm_data = perm_lrev;
            MODE_LANE_SWP: perm_data = perm_lswp;
        endcase
    end

    // Parity rides as an extra payload bit so it follows the skid path exactly
`ifdef VGA_REORDER_PARITY_EN
    assign skid_in                = {^perm_data, perm_data};
    assign {out_parity, out_data} = skid_out;
`else
    assign skid_in  = perm_data;
    assign out_data = skid_out;
`endif

    vga_skid_buffer #(
        .DW (DW)
    ) u_skid (
        .clk20ns   (clk20ns),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (skid_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

endmodule
